xs3_digit_accumulator: RTL and testbench
========================================

Name: xs3_digit_accumulator

Overview:
- Sits directly downstream of the BCD-to-Excess-3 code converter and consumes its 4-bit XS-3 output one digit per transfer.
- Checks each incoming code for legality and converts legal codes back to a decimal value.
- Adds each decimal value into an N-digit packed-BCD running total, rippling decimal carries one digit per clock.
- Flags illegal codes and total overflow; the running total feeds display/readout logic.

Parameters:
- DIGITS, 4, number of BCD digits in the running total (legal range 2..8).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  xs3_in holds a digit to transfer
- in_ready  output  1  block can accept a digit this cycle
- xs3_in  input  4  XS-3 code; bit 3 = w (MSB), bit 0 = z (LSB)
- clear  input  1  synchronous clear of total and flags
- sum_bcd  output  4*DIGITS  running total, packed BCD, digit 0 in bits [3:0]
- busy  output  1  carry propagation in progress
- overflow  output  1  sticky: total wrapped past all-9s
- code_err  output  1  sticky: an illegal code was received
- err_count  output  8  count of illegal codes, saturates at 255

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately including mid-operation): sum_bcd=0, overflow=0, code_err=0, err_count=0, busy=0, state=IDLE. in_ready=1 once rst_n is high.
- Transfer: occurs on a rising edge with in_valid=1 and in_ready=1. in_ready = (state==IDLE) & ~clear. in_ready is never combinationally dependent on in_valid.
- Legal codes: 0011..1100 (decimal 0..9 = code-3). Codes 0000, 0001, 0010, 1101, 1110 and 1111 are illegal.
- Illegal transfer: digit discarded, code_err<=1, err_count<=err_count+1 (saturating at 255), state stays IDLE, sum unchanged. in_ready stays 1, so back-to-back transfers are allowed.
- Legal transfer: addend<=code-3, idx<=0, state<=ADD.
- ADD state (busy=1, in_ready=0), one digit per cycle: s = sum_bcd[idx] + addend (5-bit).
  - s>=10: digit<=s-10, carry=1.
  - Otherwise: digit<=s, carry=0.
  - carry=0: state<=IDLE.
  - carry=1 and idx<DIGITS-1: idx<=idx+1, addend<=1, stay in ADD.
  - carry=1 and idx==DIGITS-1: overflow<=1, state<=IDLE; total has wrapped modulo 10^DIGITS.
- Latency: ADD lasts 1+k cycles, where k is the number of carries propagated. Updated sum_bcd is visible the cycle after ADD exits. Minimum transfer interval for legal digits is 2 cycles.
- sum_bcd digits are always valid BCD (0..9); no intermediate non-BCD value is ever visible.
- clear=1, sampled on a rising edge in any state: sum_bcd=0, overflow=0, code_err=0, err_count=0, state<=IDLE. Any in-progress carry ripple is abandoned. Since in_ready=0 while clear=1, no transfer can coincide with clear.
- Flags: overflow and code_err are cleared only by clear or reset. A single transfer never sets both.
- in_valid during ADD: ignored; the source must hold the digit until in_ready=1.

Test Plan:
- Reset: assert rst_n=0 -> sum_bcd=0x0000, all flags 0, err_count=0. Release -> in_ready=1, busy=0.
- Feed 0111 then 1000 -> sum_bcd=0x0009. Each ADD lasts 1 cycle (busy high 1 cycle). in_ready low exactly 1 cycle per digit.
- From 0x0009, feed 0100 -> sum_bcd=0x0010, busy high 2 cycles. Then from 0x0999, feed 0100 -> 0x1000, busy high 4 cycles.
- From 0x9999, feed 0100 -> sum_bcd=0x0000, overflow=1 and sticky through a further legal digit 0101 (sum 0x0002).
- Feed 0000, 1111, 1101 back-to-back -> code_err=1, err_count=3, sum unchanged, in_ready stays 1. Feed 260 illegal codes -> err_count=255.
- Assert clear during the 2nd ADD cycle of a 0x0999+1 ripple, with in_valid=1 -> no transfer accepted, sum_bcd=0x0000, flags 0, state IDLE next cycle. Assert rst_n low mid-ADD -> outputs zero without waiting for a clock edge.

Source files
------------

// File: rtl/xs3_digit_accumulator.sv
// Excess-3 digit accumulator: validates XS-3 codes from the upstream converter
// and adds each decoded digit into a packed-BCD running total, one carry per clock.

module xs3_digit_cell (
  input  logic       sel,
  input  logic [3:0] digit,
  input  logic [3:0] addend,
  output logic [3:0] digit_nxt,
  output logic       carry
);
  logic [4:0] s;
  logic [4:0] s_m10;

  // Non-selected cells pass their digit through, so the top can load all digits at once.
  always_comb begin
    s         = {1'b0, digit} + {1'b0, addend};
    s_m10     = s - 5'd10;
    digit_nxt = digit;
    carry     = 1'b0;
    if (sel) begin
      if (s >= 5'd10) begin
        digit_nxt = s_m10[3:0];
        carry     = 1'b1;
      end else begin
        digit_nxt = s[3:0];
      end
    end
  end
endmodule

module xs3_digit_accumulator #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            xs3_in,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   sum_bcd,
  output logic                  busy,
  output logic                  overflow,
  output logic                  code_err,
  output logic [7:0]            err_count
);
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(DIGITS - 1);

  typedef enum logic {IDLE, ADD} state_t;

  state_t                  state;
  logic [IDXW-1:0]         idx;
  logic [3:0]              addend;
  logic [DIGITS-1:0][3:0]  sum_q;
  logic [DIGITS-1:0][3:0]  dig_nxt;
  logic [DIGITS-1:0]       dig_cy;
  logic                    carry;
  logic                    xfer;
  logic                    legal;
  logic [3:0]              code_val;

  assign in_ready = (state == IDLE) & ~clear;
  assign busy     = (state == ADD);
  assign sum_bcd  = sum_q;
  assign xfer     = in_valid & in_ready;
  assign legal    = (xs3_in >= 4'd3) && (xs3_in <= 4'd12);
  assign code_val = xs3_in - 4'd3;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      xs3_digit_cell u_cell (
        .sel       (busy && (idx == IDXW'(g))),
        .digit     (sum_q[g]),
        .addend    (addend),
        .digit_nxt (dig_nxt[g]),
        .carry     (dig_cy[g])
      );
    end
  endgenerate

  // Only the selected cell can raise a carry.
  assign carry = |dig_cy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      addend    <= '0;
      sum_q     <= '0;
      overflow  <= 1'b0;
      code_err  <= 1'b0;
      err_count <= '0;
    end else if (clear) begin
      state     <= IDLE;
      idx       <= '0;
      addend    <= '0;
      sum_q     <= '0;
      overflow  <= 1'b0;
      code_err  <= 1'b0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            if (legal) begin
              addend <= code_val;
              idx    <= '0;
              state  <= ADD;
            end else begin
              code_err <= 1'b1;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
          end
        end
        ADD: begin
          sum_q <= dig_nxt;
          if (!carry) begin
            state <= IDLE;
          end else if (idx == IDX_LAST) begin
            // Wrapped modulo 10^DIGITS.
            overflow <= 1'b1;
            state    <= IDLE;
          end else begin
            idx    <= idx + IDXW'(1);
            addend <= 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_xs3_digit_accumulator.sv
// Directed bench for xs3_digit_accumulator (DIGITS=4) with hand-computed expectations.

module tb_xs3_digit_accumulator;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  xs3_in;
  logic        clear;
  logic [15:0] sum_bcd;
  logic        busy;
  logic        overflow;
  logic        code_err;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  xs3_digit_accumulator #(.DIGITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .xs3_in    (xs3_in),
    .clear     (clear),
    .sum_bcd   (sum_bcd),
    .busy      (busy),
    .overflow  (overflow),
    .code_err  (code_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  // Drive one digit, then count ADD cycles and cycles with in_ready low until idle.
  task automatic xfer(input logic [3:0] code, output int busy_cyc, output int rdy_low);
    int w;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL xfer_wait_ready: in_ready=%0b required 1", in_ready);
    end
    in_valid = 1'b1;
    xs3_in   = code;
    @(posedge clk); #1;
    in_valid = 1'b0;
    busy_cyc = 0;
    rdy_low  = 0;
    while (busy && busy_cyc < 20) begin
      if (!in_ready) rdy_low++;
      busy_cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic feed_n(input logic [3:0] code, input int n);
    int b, r;
    for (int i = 0; i < n; i++) xfer(code, b, r);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; xs3_in = 4'd0; clear = 1'b0;
    #12;
    checks++;
    if (sum_bcd !== 16'h0000 || overflow !== 1'b0 || code_err !== 1'b0 || err_count !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: sum=%h ovf=%b cerr=%b ecnt=%0d busy=%b required 0000 0 0 0 0", sum_bcd, overflow, code_err, err_count, busy);
    end
    @(negedge clk); rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b busy=%b required 1 0", in_ready, busy);
    end
  endtask

  task automatic test_basic();
    int b, r;
    xfer(4'b0111, b, r);
    checks++;
    if (sum_bcd !== 16'h0004 || b != 1 || r != 1) begin
      errors++;
      $display("FAIL basic_first: sum=%h busy_cyc=%0d rdy_low=%0d required 0004 1 1", sum_bcd, b, r);
    end
    xfer(4'b1000, b, r);
    checks++;
    if (sum_bcd !== 16'h0009 || b != 1 || r != 1) begin
      errors++;
      $display("FAIL basic_second: sum=%h busy_cyc=%0d rdy_low=%0d required 0009 1 1", sum_bcd, b, r);
    end
  endtask

  task automatic test_carry();
    int b, r;
    xfer(4'b0100, b, r);
    checks++;
    if (sum_bcd !== 16'h0010 || b != 2) begin
      errors++;
      $display("FAIL carry_one: sum=%h busy_cyc=%0d required 0010 2", sum_bcd, b);
    end
    do_clear();
    feed_n(4'b1100, 111);
    checks++;
    if (sum_bcd !== 16'h0999) begin
      errors++;
      $display("FAIL carry_build999: sum=%h required 0999", sum_bcd);
    end
    xfer(4'b0100, b, r);
    checks++;
    if (sum_bcd !== 16'h1000 || b != 4 || r != 4 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL carry_ripple3: sum=%h busy_cyc=%0d rdy_low=%0d ovf=%b required 1000 4 4 0", sum_bcd, b, r, overflow);
    end
  endtask

  task automatic test_overflow();
    int b, r;
    do_clear();
    feed_n(4'b1100, 1111);
    checks++;
    if (sum_bcd !== 16'h9999 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_build9999: sum=%h ovf=%b required 9999 0", sum_bcd, overflow);
    end
    xfer(4'b0100, b, r);
    checks++;
    if (sum_bcd !== 16'h0000 || overflow !== 1'b1 || b != 4 || code_err !== 1'b0) begin
      errors++;
      $display("FAIL ovf_wrap: sum=%h ovf=%b busy_cyc=%0d cerr=%b required 0000 1 4 0", sum_bcd, overflow, b, code_err);
    end
    xfer(4'b0101, b, r);
    checks++;
    if (sum_bcd !== 16'h0002 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: sum=%h ovf=%b required 0002 1", sum_bcd, overflow);
    end
  endtask

  task automatic test_illegal();
    logic rdy_ok;
    logic [3:0] codes [3];
    @(negedge clk);
    in_valid = 1'b1;
    xs3_in = 4'b0000; rdy_ok = in_ready;
    @(posedge clk); #1;
    xs3_in = 4'b1111; rdy_ok = rdy_ok & in_ready & ~busy;
    @(posedge clk); #1;
    xs3_in = 4'b1101; rdy_ok = rdy_ok & in_ready & ~busy;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rdy_ok = rdy_ok & in_ready & ~busy;
    checks++;
    if (code_err !== 1'b1 || err_count !== 8'd3 || sum_bcd !== 16'h0002 || rdy_ok !== 1'b1) begin
      errors++;
      $display("FAIL illegal_b2b: cerr=%b ecnt=%0d sum=%h rdy_ok=%b required 1 3 0002 1", code_err, err_count, sum_bcd, rdy_ok);
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL illegal_ovf_kept: ovf=%b required 1", overflow);
    end
    codes[0] = 4'b0001; codes[1] = 4'b0010; codes[2] = 4'b1110;
    @(negedge clk);
    in_valid = 1'b1;
    for (int i = 0; i < 260; i++) begin
      xs3_in = codes[i % 3];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (err_count !== 8'd255 || sum_bcd !== 16'h0002 || busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal_saturate: ecnt=%0d sum=%h busy=%b required 255 0002 0", err_count, sum_bcd, busy);
    end
  endtask

  task automatic test_boundary();
    int b, r;
    do_clear();
    checks++;
    if (err_count !== 8'd0 || code_err !== 1'b0 || overflow !== 1'b0 || sum_bcd !== 16'h0000) begin
      errors++;
      $display("FAIL clear_idle: ecnt=%0d cerr=%b ovf=%b sum=%h required 0 0 0 0000", err_count, code_err, overflow, sum_bcd);
    end
    xfer(4'b0011, b, r);
    checks++;
    if (sum_bcd !== 16'h0000 || b != 1 || code_err !== 1'b0) begin
      errors++;
      $display("FAIL legal_low: sum=%h busy_cyc=%0d cerr=%b required 0000 1 0", sum_bcd, b, code_err);
    end
    xfer(4'b1100, b, r);
    checks++;
    if (sum_bcd !== 16'h0009 || b != 1 || code_err !== 1'b0) begin
      errors++;
      $display("FAIL legal_high: sum=%h busy_cyc=%0d cerr=%b required 0009 1 0", sum_bcd, b, code_err);
    end
  endtask

  task automatic test_clear_mid();
    do_clear();
    feed_n(4'b1100, 111);
    @(negedge clk);
    in_valid = 1'b1; xs3_in = 4'b0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (code_err !== 1'b1 || err_count !== 8'd1 || sum_bcd !== 16'h0999) begin
      errors++;
      $display("FAIL clrmid_setup: cerr=%b ecnt=%0d sum=%h required 1 1 0999", code_err, err_count, sum_bcd);
    end
    @(negedge clk);
    in_valid = 1'b1; xs3_in = 4'b0100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clear = 1'b1;
    xs3_in = 4'b1000;
    #1;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL clrmid_ready: in_ready=%b busy=%b required 0 1", in_ready, busy);
    end
    @(posedge clk); #1;
    clear = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (sum_bcd !== 16'h0000 || overflow !== 1'b0 || code_err !== 1'b0 || err_count !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clrmid_result: sum=%h ovf=%b cerr=%b ecnt=%0d busy=%b required 0000 0 0 0 0", sum_bcd, overflow, code_err, err_count, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (sum_bcd !== 16'h0000 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL clrmid_no_xfer: sum=%h busy=%b in_ready=%b required 0000 0 1", sum_bcd, busy, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int b, r;
    xfer(4'b1100, b, r);
    @(negedge clk);
    in_valid = 1'b1; xs3_in = 4'b1111;
    @(posedge clk); #1;
    xs3_in = 4'b0100;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || sum_bcd !== 16'h0009 || code_err !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_setup: busy=%b sum=%h cerr=%b required 1 0009 1", busy, sum_bcd, code_err);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (sum_bcd !== 16'h0000 || busy !== 1'b0 || code_err !== 1'b0 || err_count !== 8'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: sum=%h busy=%b cerr=%b ecnt=%0d ovf=%b required 0000 0 0 0 0", sum_bcd, busy, code_err, err_count, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_release: in_ready=%b busy=%b required 1 0", in_ready, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_overflow();
    test_illegal();
    test_boundary();
    test_clear_mid();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
